// File: rtl/bus_handshakes_pkg.sv
// rtl/bus_handshakes_pkg.sv - shared constants for the valid/ready register slice family
// Purpose: MODE encodings, stage-count limits and the occupancy-width helper shared by the
//          slice top, its stage sub-module and the source/destination benches around it.
// Ports:   none (package)
package bus_handshakes_pkg;

  localparam int MODE_BYPASS   = 0;
  localparam int MODE_FORWARD  = 1;
  localparam int MODE_BACKWARD = 2;
  localparam int MODE_FULL     = 3;

  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 8;

  // Beats held by one stage: 0..2 (main + skid in FULL mode).
  typedef logic [1:0] stage_count_t;

  // Each stage holds at most two beats, so a chain has 2*stages+1 distinct counts.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/bus_handshakes_slice_stage.sv
// rtl/bus_handshakes_slice_stage.sv - one valid/ready register stage (forward, backward or skid)
// Purpose: single link of the slice chain; MODE picks which side of the handshake is registered.
// Ports:
//   clk                          rising-edge clock
//   clear                        synchronous clear of every held beat (reset or flush)
//   up_valid/up_data/up_ready    upstream handshake (beats enter here)
//   dn_valid/dn_data/dn_ready    downstream handshake (beats leave here)
//   count                        beats currently held by this stage, 0..2
module bus_handshakes_slice_stage
  import bus_handshakes_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int MODE  = MODE_FULL
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready,
  output stage_count_t     count
);

  generate
    if (MODE == MODE_FORWARD) begin : g_forward
      logic             full_q;
      logic [WIDTH-1:0] data_q;

      // Ready looks through to downstream so a full register still streams 1 beat/cycle.
      assign up_ready = !full_q || dn_ready;
      assign dn_valid = full_q;
      assign dn_data  = data_q;
      assign count    = {1'b0, full_q};

      always_ff @(posedge clk) begin
        if (clear) begin
          full_q <= 1'b0;
          data_q <= '0;
        end else if (up_ready) begin
          full_q <= up_valid;
          if (up_valid) begin
            data_q <= up_data;
          end
        end
      end

    end else if (MODE == MODE_BACKWARD) begin : g_backward
      logic             skid_q;
      logic [WIDTH-1:0] skid_data_q;

      // Ready comes straight from a flop; data bypasses the skid while it is empty.
      assign up_ready = !skid_q;
      assign dn_valid = skid_q || up_valid;
      assign dn_data  = skid_q ? skid_data_q : up_data;
      assign count    = {1'b0, skid_q};

      always_ff @(posedge clk) begin
        if (clear) begin
          skid_q      <= 1'b0;
          skid_data_q <= '0;
        end else if (skid_q) begin
          if (dn_ready) begin
            skid_q <= 1'b0;
          end
        end else if (up_valid && !dn_ready) begin
          // Beat was accepted (ready high) but downstream stalled: park it.
          skid_q      <= 1'b1;
          skid_data_q <= up_data;
        end
      end

    end else if (MODE == MODE_FULL) begin : g_full
      logic             main_q;
      logic             skid_q;
      logic [WIDTH-1:0] main_data_q;
      logic [WIDTH-1:0] skid_data_q;

      // Both handshake outputs come from flops; skid is only ever occupied while main is.
      assign up_ready = !skid_q;
      assign dn_valid = main_q;
      assign dn_data  = main_data_q;
      assign count    = stage_count_t'({1'b0, main_q}) + stage_count_t'({1'b0, skid_q});

      always_ff @(posedge clk) begin
        if (clear) begin
          main_q      <= 1'b0;
          skid_q      <= 1'b0;
          main_data_q <= '0;
          skid_data_q <= '0;
        end else if (skid_q) begin
          // Upstream is blocked; on release the skid beat moves into main.
          if (dn_ready) begin
            main_data_q <= skid_data_q;
            skid_q      <= 1'b0;
          end
        end else if (!main_q || dn_ready) begin
          main_q <= up_valid;
          if (up_valid) begin
            main_data_q <= up_data;
          end
        end else if (up_valid) begin
          skid_q      <= 1'b1;
          skid_data_q <= up_data;
        end
      end

    end else begin : g_passthrough
      assign up_ready = dn_ready;
      assign dn_valid = up_valid;
      assign dn_data  = up_data;
      assign count    = '0;
    end
  endgenerate

endmodule

// File: rtl/bus_handshakes_reg_slice.sv
// rtl/bus_handshakes_reg_slice.sv - parametrised valid/ready register slice with flush and occupancy
// Purpose: chain of STAGES register stages between a source and a destination; MODE selects
//          bypass, forward, backward or fully-registered (skid) timing for every stage.
// Ports:
//   clk           rising-edge clock
//   s_rst_n       synchronous active-low reset
//   flush         synchronous clear of all held beats, active-high
//   src_vaild     upstream beat valid
//   src_data_in   upstream payload
//   src_ready     slice accepts a beat this cycle
//   dst_vaild     downstream beat valid
//   dst_data_out  downstream payload
//   dst_ready     downstream accepts a beat this cycle
//   occupancy     beats currently held in all stage registers
module bus_handshakes_reg_slice
  import bus_handshakes_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 256,
  parameter int MODE   = MODE_FULL,
  parameter int STAGES = 1
) (
  input  logic                         clk,
  input  logic                         s_rst_n,
  input  logic                         flush,
  input  logic                         src_vaild,
  input  logic [WIDTH-1:0]             src_data_in,
  output logic                         src_ready,
  output logic                         dst_vaild,
  output logic [WIDTH-1:0]             dst_data_out,
  input  logic                         dst_ready,
  output logic [occ_width(STAGES)-1:0] occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  generate
    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("bus_handshakes_reg_slice: STAGES must be 1..8");
    end
    if (MODE < MODE_BYPASS || MODE > MODE_FULL) begin : g_bad_mode
      $error("bus_handshakes_reg_slice: MODE must be 0..3");
    end
    if (DEPTH < 1) begin : g_bad_depth
      $error("bus_handshakes_reg_slice: DEPTH must be positive");
    end
  endgenerate

  // Reset and flush both block the ports combinationally so no beat can transfer
  // on an edge that also clears the registers.
  logic enable;
  logic clear;
  assign enable = s_rst_n && !flush;
  assign clear  = !enable;

  logic             core_src_ready;
  logic             core_dst_vaild;
  logic [WIDTH-1:0] core_dst_data;

  assign src_ready    = core_src_ready && enable;
  assign dst_vaild    = core_dst_vaild && enable;
  assign dst_data_out = core_dst_data;

  generate
    if (MODE == MODE_BYPASS) begin : g_bypass
      assign core_dst_vaild = src_vaild;
      assign core_dst_data  = src_data_in;
      assign core_src_ready = dst_ready;
      assign occupancy      = '0;

    end else begin : g_chain
      logic             valid [STAGES+1];
      logic             ready [STAGES+1];
      logic [WIDTH-1:0] data  [STAGES+1];
      stage_count_t     count [STAGES];
      logic [OCC_W-1:0] total;

      assign valid[0]       = src_vaild && enable;
      assign data[0]        = src_data_in;
      assign core_src_ready = ready[0];

      assign ready[STAGES]  = dst_ready && enable;
      assign core_dst_vaild = valid[STAGES];
      assign core_dst_data  = data[STAGES];

      for (genvar i = 0; i < STAGES; i++) begin : g_stage
        bus_handshakes_slice_stage #(
          .WIDTH (WIDTH),
          .MODE  (MODE)
        ) u_stage (
          .clk      (clk),
          .clear    (clear),
          .up_valid (valid[i]),
          .up_data  (data[i]),
          .up_ready (ready[i]),
          .dn_valid (valid[i+1]),
          .dn_data  (data[i+1]),
          .dn_ready (ready[i+1]),
          .count    (count[i])
        );
      end

      // Occupancy is the sum of per-stage flop-held counts: it only moves on a clock
      // edge, by +1 per accepted and -1 per delivered beat, and clears with the stages.
      always_comb begin
        total = '0;
        for (int i = 0; i < STAGES; i++) begin
          total = total + OCC_W'(count[i]);
        end
      end

      assign occupancy = total;
    end
  endgenerate

endmodule

// File: tb/tb_bus_handshakes_reg_slice.sv
// tb/tb_bus_handshakes_reg_slice.sv - self-checking bench for bus_handshakes_reg_slice
module tb_bus_handshakes_reg_slice;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Instance a: MODE3 STAGES1
  logic       a_rst, a_fl, a_sv, a_sr, a_dv, a_dr;
  logic [8:0] a_sd, a_dd;
  logic [1:0] a_occ;
  bus_handshakes_reg_slice #(.WIDTH(9), .DEPTH(256), .MODE(3), .STAGES(1)) u_a (
    .clk(clk), .s_rst_n(a_rst), .flush(a_fl), .src_vaild(a_sv), .src_data_in(a_sd),
    .src_ready(a_sr), .dst_vaild(a_dv), .dst_data_out(a_dd), .dst_ready(a_dr), .occupancy(a_occ));

  // Instance b: MODE3 STAGES2
  logic       b_rst, b_fl, b_sv, b_sr, b_dv, b_dr;
  logic [8:0] b_sd, b_dd;
  logic [2:0] b_occ;
  bus_handshakes_reg_slice #(.WIDTH(9), .DEPTH(256), .MODE(3), .STAGES(2)) u_b (
    .clk(clk), .s_rst_n(b_rst), .flush(b_fl), .src_vaild(b_sv), .src_data_in(b_sd),
    .src_ready(b_sr), .dst_vaild(b_dv), .dst_data_out(b_dd), .dst_ready(b_dr), .occupancy(b_occ));

  // Instances r[m]: MODE m, STAGES3
  logic       rst_r;
  logic       r_sv [4];
  logic       r_sr [4];
  logic       r_dv [4];
  logic       r_dr [4];
  logic [8:0] r_sd [4];
  logic [8:0] r_dd [4];
  logic [2:0] r_occ [4];
  for (genvar g = 0; g < 4; g++) begin : g_r
    bus_handshakes_reg_slice #(.WIDTH(9), .DEPTH(256), .MODE(g), .STAGES(3)) u_dut (
      .clk(clk), .s_rst_n(rst_r), .flush(1'b0), .src_vaild(r_sv[g]), .src_data_in(r_sd[g]),
      .src_ready(r_sr[g]), .dst_vaild(r_dv[g]), .dst_data_out(r_dd[g]), .dst_ready(r_dr[g]),
      .occupancy(r_occ[g]));
  end

  typedef struct packed {
    logic       rst_n;
    logic       fl;
    logic       sv;
    logic [8:0] sd;
    logic       dr;
    logic       e_sr;
    logic       e_dv;
    logic [8:0] e_dd;
    logic [1:0] e_occ;
  } vec_t;

  vec_t tbl [12];

  // Reference model for the random test: source k-th beat value, counts of accepted/delivered.
  int         na [4];
  int         nd [4];
  int         hs [4];
  int         hd [4];
  logic       pend [4];
  logic       stall [4];
  logic [8:0] stall_d [4];

  function automatic logic [8:0] beat(input int m, input int k);
    return 9'((k + 37 * m) % 512);
  endfunction

  task automatic rand_cycle(input int lim, input logic drain);
    for (int m = 0; m < 4; m++) begin
      if (drain) begin
        if (!pend[m]) r_sv[m] = 1'b0;
        r_dr[m] = 1'b1;
      end else begin
        if (hs[m] == 0) begin
          if (!pend[m]) begin
            r_sv[m] = !r_sv[m];
            hs[m]   = int'($urandom_range(2, lim));
          end
        end else begin
          hs[m]--;
        end
        if (hd[m] == 0) begin
          r_dr[m] = !r_dr[m];
          hd[m]   = int'($urandom_range(2, lim));
        end else begin
          hd[m]--;
        end
      end
      r_sd[m] = beat(m, na[m]);
    end
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      if (stall[m]) begin
        chk($sformatf("t3_hold_valid_m%0d", m), 32'(r_dv[m]), 32'(1));
        chk($sformatf("t3_hold_data_m%0d", m), 32'(r_dd[m]), 32'(stall_d[m]));
      end
      if (r_sv[m] && r_sr[m]) na[m]++;
      if (r_dv[m] && r_dr[m]) begin
        chk($sformatf("t3_no_dup_m%0d", m), 32'(nd[m] < na[m]), 32'(1));
        chk($sformatf("t3_order_m%0d", m), 32'(r_dd[m]), 32'(beat(m, nd[m])));
        nd[m]++;
      end
      pend[m]    = r_sv[m] && !r_sr[m];
      stall[m]   = r_dv[m] && !r_dr[m];
      stall_d[m] = r_dd[m];
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t3_occ_m%0d", m), 32'(r_occ[m]), 32'(na[m] - nd[m]));
    end
  endtask

  logic       full_seen;
  logic       ev, er;
  logic [8:0] ed;

  initial begin
    //               rst fl sv  sd      dr | sr  dv  dd      occ
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 9'h00A, 1'b0, 1'b0, 1'b0, 9'h000, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 9'h00A, 1'b0, 1'b1, 1'b0, 9'h000, 2'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 9'h00B, 1'b0, 1'b1, 1'b1, 9'h00A, 2'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 9'h00C, 1'b0, 1'b0, 1'b1, 9'h00A, 2'd2};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 9'h00C, 1'b1, 1'b0, 1'b1, 9'h00A, 2'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 9'h00C, 1'b1, 1'b1, 1'b1, 9'h00B, 2'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 9'h00C, 2'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 9'h1FF, 1'b1, 1'b1, 1'b0, 9'h000, 2'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 9'h100, 1'b1, 1'b1, 1'b1, 9'h1FF, 2'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 9'h101, 1'b0, 1'b0, 1'b0, 9'h000, 2'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 9'h000, 2'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 9'h033, 1'b1, 1'b0, 1'b0, 9'h000, 2'd0};

    a_rst = 1'b0; a_fl = 1'b0; a_sv = 1'b0; a_sd = '0; a_dr = 1'b0;
    b_rst = 1'b0; b_fl = 1'b0; b_sv = 1'b0; b_sd = '0; b_dr = 1'b0;
    rst_r = 1'b0;
    for (int m = 0; m < 4; m++) begin
      r_sv[m] = 1'b0; r_sd[m] = '0; r_dr[m] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_occ_a", 32'(a_occ), 32'(0));
    chk("reset_data_a", 32'(a_dd), 32'(0));
    chk("reset_valid_a", 32'(a_dv), 32'(0));
    chk("reset_ready_a", 32'(a_sr), 32'(0));
    chk("reset_occ_b", 32'(b_occ), 32'(0));
    b_rst = 1'b1;
    rst_r = 1'b1;

    // Table-driven sequence on MODE3 STAGES1: fill/skid/release, simultaneous in+out, flush, reset.
    for (int i = 0; i < 12; i++) begin
      a_rst = tbl[i].rst_n; a_fl = tbl[i].fl; a_sv = tbl[i].sv; a_sd = tbl[i].sd; a_dr = tbl[i].dr;
      @(negedge clk);
      chk($sformatf("tbl%0d_src_ready", i), 32'(a_sr), 32'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_dst_vaild", i), 32'(a_dv), 32'(tbl[i].e_dv));
      chk($sformatf("tbl%0d_occupancy", i), 32'(a_occ), 32'(tbl[i].e_occ));
      if (tbl[i].e_dv) chk($sformatf("tbl%0d_dst_data", i), 32'(a_dd), 32'(tbl[i].e_dd));
      @(posedge clk);
      #1;
    end
    a_rst = 1'b1;

    // Test 1: back-to-back 0..255 with latency 1, no bubble.
    for (int k = 0; k <= 256; k++) begin
      a_sv = (k < 256); a_sd = 9'(k); a_dr = 1'b1;
      @(negedge clk);
      if (k < 256) chk("t1_src_ready", 32'(a_sr), 32'(1));
      if (k > 0) begin
        chk("t1_dst_vaild", 32'(a_dv), 32'(1));
        chk("t1_dst_data", 32'(a_dd), 32'(k - 1));
      end
      @(posedge clk);
      #1;
    end
    a_sv = 1'b0;

    // Test 5: reset mid-burst.
    a_sv = 1'b1; a_sd = 9'h010; a_dr = 1'b0;
    @(negedge clk);
    chk("t5_pre_ready", 32'(a_sr), 32'(1));
    @(posedge clk); #1;
    a_sd = 9'h011;
    @(posedge clk); #1;
    a_rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t5_rst_src_ready", 32'(a_sr), 32'(0));
      chk("t5_rst_dst_vaild", 32'(a_dv), 32'(0));
      @(posedge clk); #1;
    end
    chk("t5_rst_occ", 32'(a_occ), 32'(0));
    a_rst = 1'b1; a_sd = 9'h123; a_dr = 1'b1;
    @(negedge clk);
    chk("t5_rel_src_ready", 32'(a_sr), 32'(1));
    chk("t5_rel_dst_vaild", 32'(a_dv), 32'(0));
    @(posedge clk); #1;
    a_sv = 1'b0;
    @(negedge clk);
    chk("t5_new_valid", 32'(a_dv), 32'(1));
    chk("t5_new_data", 32'(a_dd), 32'(9'h123));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_no_old_beats", 32'(a_dv), 32'(0));
    @(posedge clk); #1;

    // Test 4: MODE3 STAGES2 fill to 4, flush, then 0x1FF after 2 cycles.
    full_seen = 1'b0;
    b_dr = 1'b0;
    for (int t = 0; t < 10 && !full_seen; t++) begin
      b_sv = 1'b1; b_sd = 9'(9'h040 + t);
      @(negedge clk);
      if (!b_sr) full_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("t4_full_reached", 32'(full_seen), 32'(1));
    chk("t4_occ_full", 32'(b_occ), 32'(4));
    b_sv = 1'b0; b_fl = 1'b1;
    @(negedge clk);
    chk("t4_flush_src_ready", 32'(b_sr), 32'(0));
    chk("t4_flush_dst_vaild", 32'(b_dv), 32'(0));
    @(posedge clk); #1;
    b_fl = 1'b0;
    chk("t4_occ_after_flush", 32'(b_occ), 32'(0));
    b_sv = 1'b1; b_sd = 9'h1FF; b_dr = 1'b1;
    @(negedge clk);
    chk("t4_valid_after_flush", 32'(b_dv), 32'(0));
    chk("t4_ready_after_flush", 32'(b_sr), 32'(1));
    @(posedge clk); #1;
    b_sv = 1'b0;
    @(negedge clk);
    chk("t4_latency_1", 32'(b_dv), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_latency_2_valid", 32'(b_dv), 32'(1));
    chk("t4_latency_2_data", 32'(b_dd), 32'(9'h1FF));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_flushed_never_appear", 32'(b_dv), 32'(0));
    end
    @(posedge clk); #1;

    // Test 6: MODE0 pass-through.
    for (int i = 0; i < 8; i++) begin
      ev = 1'($urandom_range(0, 1)); ed = 9'($urandom); er = 1'($urandom_range(0, 1));
      r_sv[0] = ev; r_sd[0] = ed; r_dr[0] = er;
      #1;
      chk("t6_dst_vaild", 32'(r_dv[0]), 32'(ev));
      chk("t6_dst_data", 32'(r_dd[0]), 32'(ed));
      chk("t6_src_ready", 32'(r_sr[0]), 32'(er));
      chk("t6_occ", 32'(r_occ[0]), 32'(0));
      @(posedge clk); #1;
    end
    rst_r = 1'b0; r_sv[0] = 1'b1; r_dr[0] = 1'b1;
    #1;
    chk("t6_rst_dst_vaild", 32'(r_dv[0]), 32'(0));
    chk("t6_rst_src_ready", 32'(r_sr[0]), 32'(0));
    @(posedge clk); #1;
    rst_r = 1'b1;

    // Test 3: all modes, STAGES3, random idle patterns against a counting model.
    for (int m = 0; m < 4; m++) begin
      r_sv[m] = 1'b0; r_dr[m] = 1'b0;
      na[m] = 0; nd[m] = 0; hs[m] = 0; hd[m] = 0;
      pend[m] = 1'b0; stall[m] = 1'b0; stall_d[m] = '0;
    end
    for (int rnd = 0; rnd < 10; rnd++) begin
      for (int c = 0; c < 60; c++) rand_cycle(2 + 3 * rnd, 1'b0);
    end
    for (int c = 0; c < 40; c++) rand_cycle(2, 1'b1);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t3_zero_loss_m%0d", m), 32'(nd[m]), 32'(na[m]));
      chk($sformatf("t3_traffic_m%0d", m), 32'(na[m] > 20), 32'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
